// File: rtl/instruction_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_unit_pkg
// Brief    : Shared widths, constants, the fetch-queue entry layout and a
//            PC alignment helper for the instruction fetch unit.
// Revision : 1.0 - initial release
// ============================================================================
package instruction_fetch_unit_pkg;

    localparam int          c_xlen     = 32;
    localparam int          c_inst_w   = 32;
    localparam logic [31:0] c_reset_pc = 32'h0000_0000;
    localparam logic [31:0] c_nop_inst = 32'h0000_0013;
    localparam int          c_entry_w  = c_xlen + c_inst_w;

    // One queued fetch: the PC in the upper half, the instruction word below.
    typedef struct packed {
        logic [c_xlen-1:0]   pc;
        logic [c_inst_w-1:0] inst;
    } fetch_entry_t;

    // Instructions are word aligned, so the two low address bits are dropped.
    function automatic logic [c_xlen-1:0] align_pc(input logic [c_xlen-1:0] pc);
        return {pc[c_xlen-1:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_unit_if
// Brief    : Instruction-memory, redirect and decode handshake signals of the
//            fetch unit. The master side is the fetch unit itself.
// Revision : 1.0 - initial release
// ============================================================================
interface instruction_fetch_unit_if #(
    parameter int DEPTH = 4
);
    import instruction_fetch_unit_pkg::*;

    logic [c_xlen-1:0]      imem_pc;
    logic [c_inst_w-1:0]    imem_inst;
    logic                   redirect_valid;
    logic [c_xlen-1:0]      redirect_pc;
    logic                   deq_valid;
    logic                   deq_ready;
    logic [c_inst_w-1:0]    deq_inst;
    logic [c_xlen-1:0]      deq_pc;
    logic [$clog2(DEPTH):0] occupancy;

    modport master (
        output imem_pc,
        input  imem_inst,
        input  redirect_valid,
        input  redirect_pc,
        output deq_valid,
        input  deq_ready,
        output deq_inst,
        output deq_pc,
        output occupancy
    );

    modport slave (
        input  imem_pc,
        output imem_inst,
        output redirect_valid,
        output redirect_pc,
        input  deq_valid,
        output deq_ready,
        input  deq_inst,
        input  deq_pc,
        input  occupancy
    );

endinterface
`default_nettype wire

// File: rtl/instruction_fetch_unit_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Brief    : In-order circular queue of fetched entries. Flush empties it
//            without touching storage; reset also zeroes storage.
//            The caller guarantees push only when not full and pop only
//            when not empty.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  wire logic                     clk,
    input  wire logic                     reset,
    input  wire logic                     push,
    input  wire logic                     pop,
    input  wire logic                     flush,
    input  wire logic [WIDTH-1:0]         wr_data,
    output logic      [WIDTH-1:0]         rd_data,
    output logic      [$clog2(DEPTH):0]   occupancy
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_occ_w = c_ptr_w + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_occ_w-1:0] r_occupancy;

    // Storage write, pointer advance (natural wrap, DEPTH is a power of two) and entry count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_occupancy <= '0;
        end else if (flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_occupancy <= '0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= wr_data;
                r_wr_ptr        <= r_wr_ptr + c_ptr_w'(1);
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            if (push && !pop) begin
                r_occupancy <= r_occupancy + c_occ_w'(1);
            end else if (pop && !push) begin
                r_occupancy <= r_occupancy - c_occ_w'(1);
            end
        end
    end

    assign rd_data   = r_mem[r_rd_ptr];
    assign occupancy = r_occupancy;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_unit
// Brief    : Drives the fetch PC to a combinational instruction memory,
//            queues {pc, inst} pairs and hands them to decode over a
//            valid/ready handshake. Redirects flush the queue and retarget
//            the fetch PC.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = c_reset_pc,
    parameter int          PC_STEP  = 4
) (
    input wire logic                  clk,
    input wire logic                  reset,
    instruction_fetch_unit_if.master  bus
);

    localparam int                 c_occ_w = $clog2(DEPTH) + 1;
    localparam logic [c_occ_w-1:0] c_full  = c_occ_w'(DEPTH);

    logic [c_xlen-1:0]  r_fetch_pc;
    logic               w_push;
    logic               w_pop;
    logic               w_deq_valid;
    logic [c_occ_w-1:0] w_occupancy;
    fetch_entry_t       w_wr_entry;
    fetch_entry_t       w_rd_entry;

    // A redirect blocks both sides of the queue for its cycle. Enqueue looks
    // only at the start-of-cycle count, so a full queue never bypasses.
    assign w_deq_valid = (w_occupancy != '0) && !bus.redirect_valid;
    assign w_pop       = w_deq_valid && bus.deq_ready;
    assign w_push      = (w_occupancy != c_full) && !bus.redirect_valid;

    assign w_wr_entry.pc   = r_fetch_pc;
    assign w_wr_entry.inst = bus.imem_inst;

    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (c_entry_w)
    ) u_fetch_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .pop       (w_pop),
        .flush     (bus.redirect_valid),
        .wr_data   (w_wr_entry),
        .rd_data   (w_rd_entry),
        .occupancy (w_occupancy)
    );

    // Fetch PC: redirect target wins, otherwise step past each enqueued word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
        end else if (bus.redirect_valid) begin
            r_fetch_pc <= align_pc(bus.redirect_pc);
        end else if (w_push) begin
            r_fetch_pc <= r_fetch_pc + c_xlen'(PC_STEP);
        end
    end

    assign bus.imem_pc   = r_fetch_pc;
    assign bus.deq_valid = w_deq_valid;
    assign bus.deq_inst  = w_rd_entry.inst;
    assign bus.deq_pc    = w_rd_entry.pc;
    assign bus.occupancy = w_occupancy;

endmodule
`default_nettype wire
